// File: rtl/code_entry_tx.sv
// code_entry_tx: dial a 4-bit code, submit it to the checker, show the verdict and lock out after repeated failures (CODE_ENTRY_LOCKOUT_EN builds the lockout)
module code_entry_tx #(
  parameter int TIMEOUT_TICKS = 4,
  parameter int SHOW_TICKS = 2
`ifdef CODE_ENTRY_LOCKOUT_EN
  , parameter int MAX_TRIES = 3,
  parameter int LOCK_TICKS = 10
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_next,
  input  logic       btn_send,
  input  logic       resp_valid,
  input  logic       resp_ok,
  output logic [3:0] code_out,
  output logic       code_valid,
  output logic [3:0] LED,
  output logic       locked,
  output logic [1:0] fail_cnt
);
  typedef enum logic [2:0] {EDIT, SEND, SHOW_OK, SHOW_FAIL, LOCK} state_t;
  state_t state, state_n;
  logic [3:0] code_reg, code_n, cnt, cnt_n, cnt_inc, led_n;
  logic [1:0] fail_n;
  logic flip, flip_n, fail_ev, locked_n;
  // next state, next counters and next registered outputs
  always_comb begin
    state_n = state;
    code_n = code_reg;
    fail_n = fail_cnt;
    fail_ev = 1'b0;
    cnt_inc = cnt + {3'd0, tick};
    case (state)
      EDIT: begin
        state_n = btn_send ? SEND : EDIT;
        code_n = (btn_next && !btn_send) ? code_reg + 4'd1 : code_reg;
      end
      SEND: begin
        if (resp_valid && resp_ok) begin
          state_n = SHOW_OK;
          fail_n = 2'd0;
        end else begin
          fail_ev = resp_valid || cnt_inc == 4'(TIMEOUT_TICKS);
        end
      end
      SHOW_OK: state_n = (cnt_inc == 4'(SHOW_TICKS)) ? EDIT : SHOW_OK;
      SHOW_FAIL: begin
        if (cnt_inc == 4'(SHOW_TICKS)) begin
          state_n = EDIT;
          code_n = 4'd0;
        end
      end
`ifdef CODE_ENTRY_LOCKOUT_EN
      LOCK: begin
        if (cnt_inc == 4'(LOCK_TICKS)) begin
          state_n = EDIT;
          code_n = 4'd0;
          fail_n = 2'd0;
        end
      end
`endif
      default: state_n = EDIT;
    endcase
`ifdef CODE_ENTRY_LOCKOUT_EN
    if (fail_ev) begin
      fail_n = fail_cnt + 2'd1;
      state_n = (fail_cnt + 2'd1 == 2'(MAX_TRIES)) ? LOCK : SHOW_FAIL;
    end
    locked_n = state_n == LOCK;
`else
    if (fail_ev) begin
      fail_n = (fail_cnt == 2'd3) ? 2'd3 : fail_cnt + 2'd1;
      state_n = SHOW_FAIL;
    end
    locked_n = 1'b0;
`endif
    cnt_n = (state_n != state || state == EDIT) ? 4'd0 : cnt_inc;
    flip_n = (state == SHOW_FAIL && state_n == SHOW_FAIL) ? flip ^ tick : 1'b0;
    led_n = (state_n == EDIT || state_n == SEND) ? code_n :
            (state_n == SHOW_OK) ? 4'b1111 :
            (state_n == SHOW_FAIL) ? (flip_n ? 4'b0101 : 4'b1010) : 4'b0000;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= EDIT;
      code_reg <= 4'd0;
      cnt <= 4'd0;
      flip <= 1'b0;
      fail_cnt <= 2'd0;
      LED <= 4'd0;
      code_out <= 4'd0;
      code_valid <= 1'b0;
      locked <= 1'b0;
    end else begin
      state <= state_n;
      code_reg <= code_n;
      cnt <= cnt_n;
      flip <= flip_n;
      fail_cnt <= fail_n;
      LED <= led_n;
      code_out <= (state_n == SEND) ? code_n : code_out;
      code_valid <= state_n == SEND;
      locked <= locked_n;
    end
  end
endmodule

// File: tb/tb_code_entry_tx.sv
// tb_code_entry_tx: directed vector table, corner sequences and random stimulus against a behavioural model
module tb_code_entry_tx;
`ifdef CODE_ENTRY_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, tick = 1'b0, btn_next = 1'b0, btn_send = 1'b0, resp_valid = 1'b0, resp_ok = 1'b0;
  logic [3:0] code_out, LED;
  logic code_valid, locked;
  logic [1:0] fail_cnt;
  int checks = 0, failures = 0;
  code_entry_tx dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_next(btn_next), .btn_send(btn_send),
    .resp_valid(resp_valid), .resp_ok(resp_ok), .code_out(code_out), .code_valid(code_valid),
    .LED(LED), .locked(locked), .fail_cnt(fail_cnt)
  );
  always #5 clk = ~clk;
  // model: 0 edit, 1 send, 2 show ok, 3 show fail, 4 lock; m_left counts ticks still to wait
  int m_mode = 0, m_left = 0, m_fail = 0;
  logic [3:0] m_code = 4'd0, m_out = 4'd0;
  logic m_flip = 1'b0;
  function automatic logic [3:0] m_led();
    return (m_mode == 0 || m_mode == 1) ? m_code : (m_mode == 2) ? 4'hF :
           (m_mode == 3) ? (m_flip ? 4'h5 : 4'hA) : 4'h0;
  endfunction
  task automatic m_failure();
    m_fail = LOCKOUT ? m_fail + 1 : (m_fail >= 3 ? 3 : m_fail + 1);
    if (LOCKOUT && m_fail == 3) begin
      m_mode = 4;
      m_left = 10;
    end else begin
      m_mode = 3;
      m_left = 2;
      m_flip = 1'b0;
    end
  endtask
  task automatic model(input logic r, t, n, s, v, k);
    if (!r) begin
      m_mode = 0; m_code = 0; m_out = 0; m_fail = 0; m_left = 0; m_flip = 0;
    end else begin
      case (m_mode)
        0: if (s) begin m_mode = 1; m_left = 4; m_out = m_code; end else if (n) m_code = m_code + 4'd1;
        1: begin
          if (v && k) begin m_fail = 0; m_mode = 2; m_left = 2; end
          else if (v) m_failure();
          else if (t) begin m_left--; if (m_left == 0) m_failure(); end
        end
        2: if (t) begin m_left--; if (m_left == 0) m_mode = 0; end
        3: if (t) begin m_left--; m_flip = !m_flip; if (m_left == 0) begin m_mode = 0; m_code = 0; end end
        default: if (t) begin m_left--; if (m_left == 0) begin m_mode = 0; m_fail = 0; m_code = 0; end end
      endcase
    end
  endtask
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic r, t, n, s, v, k);
    @(negedge clk);
    reset = r; tick = t; btn_next = n; btn_send = s; resp_valid = v; resp_ok = k;
    @(posedge clk);
    model(r, t, n, s, v, k);
    #1;
    chk("model", {4'd0, LED, code_out, code_valid, locked, fail_cnt},
        {4'd0, m_led(), m_out, m_mode == 1, m_mode == 4, 2'(m_fail)});
  endtask
  typedef struct {
    logic r, t, n, s, v, k;
    logic [3:0] led;
    logic cv;
    logic [3:0] co;
    logic [1:0] fc;
  } vec_t;
  vec_t tbl[18];
  initial begin
    tbl[0]  = '{0,0,0,0,0,0, 4'h0, 0, 4'h0, 2'd0};
    tbl[1]  = '{1,0,1,0,0,0, 4'h1, 0, 4'h0, 2'd0};
    tbl[2]  = '{1,0,1,0,0,0, 4'h2, 0, 4'h0, 2'd0};
    tbl[3]  = '{1,0,1,0,0,0, 4'h3, 0, 4'h0, 2'd0};
    tbl[4]  = '{1,0,1,0,0,0, 4'h4, 0, 4'h0, 2'd0};
    tbl[5]  = '{1,0,1,0,0,0, 4'h5, 0, 4'h0, 2'd0};
    tbl[6]  = '{1,0,0,1,0,0, 4'h5, 1, 4'h5, 2'd0};
    tbl[7]  = '{1,1,0,0,0,0, 4'h5, 1, 4'h5, 2'd0};
    tbl[8]  = '{1,0,0,0,1,1, 4'hF, 0, 4'h5, 2'd0};
    tbl[9]  = '{1,1,0,0,0,0, 4'hF, 0, 4'h5, 2'd0};
    tbl[10] = '{1,0,0,0,0,0, 4'hF, 0, 4'h5, 2'd0};
    tbl[11] = '{1,1,0,0,0,0, 4'h5, 0, 4'h5, 2'd0};
    tbl[12] = '{1,0,0,0,1,1, 4'h5, 0, 4'h5, 2'd0};
    tbl[13] = '{1,0,1,1,0,0, 4'h5, 1, 4'h5, 2'd0};
    tbl[14] = '{1,0,0,0,1,0, 4'hA, 0, 4'h5, 2'd1};
    tbl[15] = '{1,1,0,0,0,0, 4'h5, 0, 4'h5, 2'd1};
    tbl[16] = '{1,1,0,0,0,0, 4'h0, 0, 4'h5, 2'd1};
    tbl[17] = '{1,0,1,0,0,0, 4'h1, 0, 4'h5, 2'd1};
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].t, tbl[i].n, tbl[i].s, tbl[i].v, tbl[i].k);
      chk($sformatf("vec%0d", i), {5'd0, LED, code_valid, code_out, fail_cnt, locked},
          {5'd0, tbl[i].led, tbl[i].cv, tbl[i].co, tbl[i].fc, 1'b0});
    end
    step(0,0,0,0,0,0);
    for (int i = 0; i < 16; i++) step(1,0,1,0,0,0);
    chk("wrap", {12'd0, LED}, 16'h0);
    for (int i = 0; i < 3; i++) step(1,0,1,0,0,0);
    step(1,0,1,1,0,0);
    chk("send_wins", {11'd0, code_out, code_valid}, {11'd0, 4'h3, 1'b1});
    for (int i = 0; i < 3; i++) step(1,1,0,0,0,0);
    chk("pre_timeout", {15'd0, code_valid}, 16'd1);
    step(1,1,0,0,0,0);
    chk("timeout", {11'd0, LED, code_valid}, {11'd0, 4'hA, 1'b0});
    step(1,1,0,0,0,0);
    chk("fail_toggle", {12'd0, LED}, 16'h5);
    step(1,1,0,0,0,0);
    chk("code_clr", {12'd0, LED}, 16'h0);
    step(1,0,1,0,0,0);
    step(1,0,0,1,0,0);
    step(0,0,0,0,0,0);
    chk("rst_send", {11'd0, LED, code_valid}, 16'd0);
    step(1,0,0,0,1,1);
    chk("rv_ignored", {11'd0, LED, code_valid}, 16'd0);
    step(0,0,0,0,0,0);
    for (int i = 0; i < 3; i++) begin
      step(1,0,0,1,0,0);
      step(1,0,0,0,1,0);
      chk("fail_cnt", {14'd0, fail_cnt}, 16'(i + 1));
      if (i < 2) begin step(1,1,0,0,0,0); step(1,1,0,0,0,0); end
    end
`ifdef CODE_ENTRY_LOCKOUT_EN
    chk("lock_on", {11'd0, locked, LED}, {11'd0, 1'b1, 4'h0});
    step(1,0,1,0,0,0);
    for (int i = 0; i < 9; i++) step(1,1,1,0,0,0);
    chk("lock_hold", {11'd0, locked, LED}, {11'd0, 1'b1, 4'h0});
    step(1,1,0,0,0,0);
    chk("lock_off", {9'd0, locked, fail_cnt, LED}, 16'd0);
`else
    chk("no_lock", {15'd0, locked}, 16'd0);
    step(1,1,0,0,0,0); step(1,1,0,0,0,0);
    step(1,0,0,1,0,0); step(1,0,0,0,1,0);
    chk("fail_sat", {14'd0, fail_cnt}, 16'd3);
    step(1,1,0,0,0,0); step(1,1,0,0,0,0);
    step(1,0,0,1,0,0); step(1,0,0,0,1,1);
    chk("fail_clr", {14'd0, fail_cnt}, 16'd0);
`endif
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) != 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
           $urandom_range(4) == 0, $urandom_range(3) == 0, $urandom_range(1) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
